// File: rtl/byte_unstripping_pkg.sv
// Shared definitions for the byte un-striping block: FSM encoding and the
// set of stripe counts the reassembler supports.
package byte_unstripping_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STALL  = 2'd2
  } state_t;

  localparam int LANES_LEGAL_A = 2;
  localparam int LANES_LEGAL_B = 4;
  localparam int LANES_LEGAL_C = 8;

  function automatic bit is_legal_lanes(input int n);
    return (n == LANES_LEGAL_A) || (n == LANES_LEGAL_B) || (n == LANES_LEGAL_C);
  endfunction

endpackage

// File: rtl/bu_lane_fifo.sv
// Single-lane FIFO for the un-striping block. Storage is unreset; the
// pointers and occupancy count carry all state and are cleared by reset
// or flush. A push on a full FIFO is only legal alongside a pop, which the
// parent guarantees.
module bu_lane_fifo
  import byte_unstripping_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset_L,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  // Storage write; flush discards the word presented on the same edge.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/byte_unstripping_n.sv
// Byte un-striping: buffers LANES parallel lane streams and re-serialises
// them round-robin (lane 0 first) onto a single ready/valid output.
// Optional feature: define BYTE_UNSTRIPPING_ERR_CNT_EN to count overflow
// edges in err_count (saturating); otherwise err_count is tied to zero.
module byte_unstripping_n
  import byte_unstripping_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk_2f,
  input  logic                     reset_L,
  input  logic [LANES*DATA_W-1:0]  data_stripe,
  input  logic [LANES-1:0]         valid_stripe,
  input  logic                     flush,
  input  logic                     ready_demux,
  output logic [DATA_W-1:0]        data_demux,
  output logic                     valid_demux,
  output logic [LANES-1:0]         pause_stripe,
  output logic [7:0]               err_count
);

  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(LANES);

  if (!is_legal_lanes(LANES)) begin : g_bad_lanes
    $error("byte_unstripping_n: LANES must be 2, 4 or 8");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("byte_unstripping_n: DEPTH must be a power of 2, at least 2");
  end

  state_t            state;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  ptr_next;
  logic              out_free;
  logic              pop_en;

  logic [LANES-1:0]  lane_push;
  logic [LANES-1:0]  lane_pop;
  logic [LANES-1:0]  lane_full;
  logic [LANES-1:0]  lane_empty;
  logic [DATA_W-1:0] lane_dout  [LANES];
  logic [CW-1:0]     lane_count [LANES];

  assign out_free = !valid_demux || ready_demux;
  assign pop_en   = !flush && (state == ACTIVE) && out_free && !lane_empty[ptr];
  assign ptr_next = (ptr == PTR_W'(LANES - 1)) ? '0 : ptr + 1'b1;

  // One-hot pop strobe aimed at the lane currently owed to the output.
  always_comb begin
    lane_pop = '0;
    if (pop_en) lane_pop[ptr] = 1'b1;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_push[i]    = valid_stripe[i] && (!lane_full[i] || lane_pop[i]) && !flush;
    assign pause_stripe[i] = (lane_count[i] >= CW'(DEPTH - 1));

    bu_lane_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk     (clk_2f),
      .reset_L (reset_L),
      .flush   (flush),
      .push    (lane_push[i]),
      .pop     (lane_pop[i]),
      .din     (data_stripe[i*DATA_W +: DATA_W]),
      .dout    (lane_dout[i]),
      .count   (lane_count[i]),
      .full    (lane_full[i]),
      .empty   (lane_empty[i])
    );
  end

  // Sequencer: waits for alignment, then drains lanes in strict rotation,
  // parking on an empty lane rather than skipping it.
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      state       <= IDLE;
      ptr         <= '0;
      valid_demux <= 1'b0;
      data_demux  <= '0;
    end else if (flush) begin
      state       <= IDLE;
      ptr         <= '0;
      valid_demux <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (lane_empty == '0) state <= ACTIVE;
        end
        ACTIVE: begin
          if (out_free) begin
            if (!lane_empty[ptr]) begin
              data_demux  <= lane_dout[ptr];
              valid_demux <= 1'b1;
              ptr         <= ptr_next;
            end else begin
              state       <= STALL;
              valid_demux <= 1'b0;
            end
          end
        end
        STALL: begin
          if (!lane_empty[ptr]) state <= ACTIVE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BYTE_UNSTRIPPING_ERR_CNT_EN
  logic [LANES-1:0] lane_ovf;
  logic [7:0]       err_q;

  assign lane_ovf = valid_stripe & lane_full & ~lane_pop;

  // Count edges with at least one dropped push, saturating at 255.
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      err_q <= '0;
    end else if (!flush && (lane_ovf != '0) && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_byte_unstripping_n.sv
// Self-checking bench for byte_unstripping_n (LANES=2, DATA_W=8, DEPTH=4).
// Directed scenarios use literal expectations; the random phase checks the
// output stream against per-lane queues interleaved round-robin.
module tb_byte_unstripping_n;

  localparam int LANES  = 2;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic                    clk_2f;
  logic                    reset_L;
  logic [LANES*DATA_W-1:0] data_stripe;
  logic [LANES-1:0]        valid_stripe;
  logic                    flush;
  logic                    ready_demux;
  logic [DATA_W-1:0]       data_demux;
  logic                    valid_demux;
  logic [LANES-1:0]        pause_stripe;
  logic [7:0]              err_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         model_ptr;
  logic [7:0] exp_err;

  byte_unstripping_n #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk_2f       (clk_2f),
    .reset_L      (reset_L),
    .data_stripe  (data_stripe),
    .valid_stripe (valid_stripe),
    .flush        (flush),
    .ready_demux  (ready_demux),
    .data_demux   (data_demux),
    .valid_demux  (valid_demux),
    .pause_stripe (pause_stripe),
    .err_count    (err_count)
  );

  initial clk_2f = 1'b0;
  always #5 clk_2f = ~clk_2f;

  // Drive one cycle of inputs, step past the rising edge, then drop strobes.
  task automatic applyStimulus(input logic [1:0] v, input logic [15:0] d,
                               input logic rdy, input logic fl);
    valid_stripe = v;
    data_stripe  = d;
    ready_demux  = rdy;
    flush        = fl;
    @(posedge clk_2f);
    #1;
    valid_stripe = '0;
    flush        = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Output word currently offered, tagged with valid in bit 8.
  function automatic logic [31:0] outWord();
    return {23'd0, valid_demux, data_demux};
  endfunction

  // Consume the word being accepted on the coming edge and compare with the model.
  task automatic consumeWord();
    logic [7:0] exp;
    int         sz;
    sz = (model_ptr == 0) ? q0.size() : q1.size();
    if (sz == 0) begin
      checkOutput("rand_extra_word", {31'd0, valid_demux}, 32'd0);
    end else begin
      exp = (model_ptr == 0) ? q0.pop_front() : q1.pop_front();
      checkOutput("rand_data", {24'd0, data_demux}, {24'd0, exp});
      model_ptr = (model_ptr + 1) % LANES;
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]  v;
    logic [15:0] d;
    logic        rdy;

`ifdef BYTE_UNSTRIPPING_ERR_CNT_EN
    exp_err = 8'd2;
`else
    exp_err = 8'd0;
`endif

    reset_L      = 1'b0;
    data_stripe  = '0;
    valid_stripe = '0;
    flush        = 1'b0;
    ready_demux  = 1'b1;
    #12;
    checkOutput("reset_valid", {31'd0, valid_demux}, 32'd0);
    checkOutput("reset_data",  {24'd0, data_demux}, 32'd0);
    checkOutput("reset_err",   {24'd0, err_count}, 32'd0);
    checkOutput("reset_pause", {30'd0, pause_stripe}, 32'd0);
    reset_L = 1'b1;
    applyStimulus(2'b00, 16'h0000, 1'b1, 1'b0);

    // Basic two-lane reassembly with exact first-word latency.
    $display("[TB] basic reassembly");
    applyStimulus(2'b11, 16'hB0A0, 1'b1, 1'b0);
    checkOutput("s1_after_push0", {31'd0, valid_demux}, 32'd0);
    applyStimulus(2'b11, 16'hB1A1, 1'b1, 1'b0);
    checkOutput("s1_after_push1", {31'd0, valid_demux}, 32'd0);
    applyStimulus(2'b00, 16'h0000, 1'b1, 1'b0);
    checkOutput("s1_word_a0", outWord(), 32'h1A0);
    applyStimulus(2'b00, 16'h0000, 1'b1, 1'b0);
    checkOutput("s1_word_b0", outWord(), 32'h1B0);
    applyStimulus(2'b00, 16'h0000, 1'b1, 1'b0);
    checkOutput("s1_word_a1", outWord(), 32'h1A1);
    applyStimulus(2'b00, 16'h0000, 1'b1, 1'b0);
    checkOutput("s1_word_b1", outWord(), 32'h1B1);
    applyStimulus(2'b00, 16'h0000, 1'b1, 1'b0);
    checkOutput("s1_stall_empty", {31'd0, valid_demux}, 32'd0);

    // Partial alignment must not release data.
    $display("[TB] partial alignment");
    applyStimulus(2'b00, 16'h0000, 1'b1, 1'b1);
    applyStimulus(2'b01, 16'h00C0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(2'b00, 16'h0000, 1'b1, 1'b0);
    checkOutput("s2_idle_partial", {31'd0, valid_demux}, 32'd0);
    applyStimulus(2'b10, 16'hD000, 1'b1, 1'b0);
    checkOutput("s2_align_edge", {31'd0, valid_demux}, 32'd0);
    applyStimulus(2'b00, 16'h0000, 1'b1, 1'b0);
    checkOutput("s2_active_edge", {31'd0, valid_demux}, 32'd0);
    applyStimulus(2'b00, 16'h0000, 1'b1, 1'b0);
    checkOutput("s2_word_c0", outWord(), 32'h1C0);
    applyStimulus(2'b00, 16'h0000, 1'b1, 1'b0);
    checkOutput("s2_word_d0", outWord(), 32'h1D0);
    applyStimulus(2'b00, 16'h0000, 1'b1, 1'b0);
    checkOutput("s2_stall", {31'd0, valid_demux}, 32'd0);

    // Backpressure: output holds for three cycles, order resumes intact.
    $display("[TB] backpressure");
    applyStimulus(2'b11, 16'h2111, 1'b1, 1'b0);
    applyStimulus(2'b11, 16'h2212, 1'b1, 1'b0);
    applyStimulus(2'b11, 16'h2313, 1'b1, 1'b0);
    checkOutput("s3_first", outWord(), 32'h111);
    checkOutput("s3_pause", {30'd0, pause_stripe}, 32'd2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b00, 16'h0000, 1'b0, 1'b0);
      checkOutput("s3_hold", outWord(), 32'h111);
    end
    applyStimulus(2'b00, 16'h0000, 1'b1, 1'b0);
    checkOutput("s3_word_21", outWord(), 32'h121);
    applyStimulus(2'b00, 16'h0000, 1'b1, 1'b0);
    checkOutput("s3_word_12", outWord(), 32'h112);
    applyStimulus(2'b00, 16'h0000, 1'b1, 1'b0);
    checkOutput("s3_word_22", outWord(), 32'h122);
    applyStimulus(2'b00, 16'h0000, 1'b1, 1'b0);
    checkOutput("s3_word_13", outWord(), 32'h113);
    applyStimulus(2'b00, 16'h0000, 1'b1, 1'b0);
    checkOutput("s3_word_23", outWord(), 32'h123);
    applyStimulus(2'b00, 16'h0000, 1'b1, 1'b0);
    checkOutput("s3_drained", {31'd0, valid_demux}, 32'd0);

    // Lane 1 starved: stall on lane 1 without re-reading lane 0.
    $display("[TB] starved lane");
    applyStimulus(2'b11, 16'h4030, 1'b1, 1'b0);
    applyStimulus(2'b01, 16'h0031, 1'b1, 1'b0);
    applyStimulus(2'b01, 16'h0032, 1'b1, 1'b0);
    checkOutput("s4_word_30", outWord(), 32'h130);
    applyStimulus(2'b00, 16'h0000, 1'b1, 1'b0);
    checkOutput("s4_word_40", outWord(), 32'h140);
    applyStimulus(2'b00, 16'h0000, 1'b1, 1'b0);
    checkOutput("s4_word_31", outWord(), 32'h131);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b00, 16'h0000, 1'b1, 1'b0);
      checkOutput("s4_stalled", {31'd0, valid_demux}, 32'd0);
    end
    applyStimulus(2'b10, 16'h4100, 1'b1, 1'b0);
    applyStimulus(2'b00, 16'h0000, 1'b1, 1'b0);
    checkOutput("s4_resume_edge", {31'd0, valid_demux}, 32'd0);
    applyStimulus(2'b00, 16'h0000, 1'b1, 1'b0);
    checkOutput("s4_word_41", outWord(), 32'h141);
    applyStimulus(2'b00, 16'h0000, 1'b1, 1'b0);
    checkOutput("s4_word_32", outWord(), 32'h132);

    // Overflow: six pushes into a DEPTH=4 lane while lane 1 stays empty.
    $display("[TB] overflow");
    applyStimulus(2'b00, 16'h0000, 1'b1, 1'b1);
    checkOutput("s5_flush_pause", {30'd0, pause_stripe}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(2'b01, {8'h00, 8'(8'h50 + i)}, 1'b1, 1'b0);
      if (i == 1) checkOutput("s5_pause_cnt2", {30'd0, pause_stripe}, 32'd0);
      if (i == 2) checkOutput("s5_pause_cnt3", {30'd0, pause_stripe}, 32'd1);
    end
    checkOutput("s5_pause_full", {30'd0, pause_stripe}, 32'd1);
    checkOutput("s5_err_count", {24'd0, err_count}, {24'd0, exp_err});
    applyStimulus(2'b10, 16'h6000, 1'b1, 1'b0);
    applyStimulus(2'b00, 16'h0000, 1'b1, 1'b0);
    applyStimulus(2'b00, 16'h0000, 1'b1, 1'b0);
    checkOutput("s5_word_50", outWord(), 32'h150);
    applyStimulus(2'b00, 16'h0000, 1'b1, 1'b0);
    checkOutput("s5_word_60", outWord(), 32'h160);
    applyStimulus(2'b00, 16'h0000, 1'b1, 1'b0);
    checkOutput("s5_word_51", outWord(), 32'h151);
    applyStimulus(2'b00, 16'h0000, 1'b1, 1'b0);
    checkOutput("s5_stall_l1", {31'd0, valid_demux}, 32'd0);

    // Asynchronous reset mid-stream, then fresh alignment required.
    $display("[TB] reset mid-stream");
    applyStimulus(2'b10, 16'h6100, 1'b1, 1'b0);
    applyStimulus(2'b00, 16'h0000, 1'b1, 1'b0);
    applyStimulus(2'b00, 16'h0000, 1'b1, 1'b0);
    checkOutput("s6_word_61", outWord(), 32'h161);
    #2;
    reset_L = 1'b0;
    #1;
    checkOutput("s6_rst_valid", {31'd0, valid_demux}, 32'd0);
    checkOutput("s6_rst_data",  {24'd0, data_demux}, 32'd0);
    checkOutput("s6_rst_err",   {24'd0, err_count}, 32'd0);
    checkOutput("s6_rst_pause", {30'd0, pause_stripe}, 32'd0);
    applyStimulus(2'b00, 16'h0000, 1'b1, 1'b0);
    reset_L = 1'b1;
    applyStimulus(2'b01, 16'h0070, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(2'b00, 16'h0000, 1'b1, 1'b0);
    checkOutput("s6_realign_wait", {31'd0, valid_demux}, 32'd0);
    applyStimulus(2'b10, 16'h8000, 1'b1, 1'b0);
    applyStimulus(2'b00, 16'h0000, 1'b1, 1'b0);
    applyStimulus(2'b00, 16'h0000, 1'b1, 1'b0);
    checkOutput("s6_word_70", outWord(), 32'h170);
    applyStimulus(2'b00, 16'h0000, 1'b1, 1'b0);
    checkOutput("s6_word_80", outWord(), 32'h180);
    applyStimulus(2'b00, 16'h0000, 1'b1, 1'b0);

    // Flush mid-stream wins over a simultaneous push.
    $display("[TB] flush mid-stream");
    applyStimulus(2'b11, 16'h8171, 1'b1, 1'b0);
    applyStimulus(2'b11, 16'h8272, 1'b1, 1'b0);
    applyStimulus(2'b11, 16'h8373, 1'b1, 1'b0);
    checkOutput("s7_word_71", outWord(), 32'h171);
    applyStimulus(2'b11, 16'h8474, 1'b1, 1'b1);
    checkOutput("s7_flush_valid", {31'd0, valid_demux}, 32'd0);
    checkOutput("s7_flush_pause", {30'd0, pause_stripe}, 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(2'b00, 16'h0000, 1'b1, 1'b0);
    checkOutput("s7_flush_empty", {31'd0, valid_demux}, 32'd0);

    // Randomized traffic against the round-robin queue model.
    $display("[TB] random traffic");
    model_ptr = 0;
    for (int c = 0; c < 400; c++) begin
      v   = '0;
      d   = '0;
      rdy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < LANES; i++) begin
        if (!pause_stripe[i] && $urandom_range(0, 1) == 1) begin
          v[i]          = 1'b1;
          d[i*8 +: 8]   = 8'($urandom);
        end
      end
      if (valid_demux && rdy) consumeWord();
      if (v[0]) q0.push_back(d[7:0]);
      if (v[1]) q1.push_back(d[15:8]);
      applyStimulus(v, d, rdy, 1'b0);
    end
    for (int c = 0; c < 40; c++) begin
      if (valid_demux) consumeWord();
      applyStimulus(2'b00, 16'h0000, 1'b1, 1'b0);
    end
    checkOutput("drain_valid", {31'd0, valid_demux}, 32'd0);
    checkOutput("drain_left", (model_ptr == 0) ? q0.size() : q1.size(), 32'd0);
    checkOutput("final_err", {24'd0, err_count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
